// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Bundles the start/busy/done handshake, operands and result of the
//   nibble-serial adder.
//   Handshake: start is a request taken only when the adder is idle or
//   finishing (busy=0); a/b (and sub) are sampled on that same edge.
//   busy stays high while the nibbles are being computed, and done pulses
//   for one cycle when s/cout/ovf are final. start seen while busy=1 is dropped.
//   Optional macro NIBBLE_SUB_EN adds the sub (subtract select) signal.
//   Modports: master drives the request side, slave is the adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  logic                 start;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
`ifdef NIBBLE_SUB_EN
  logic                 sub;
`endif
  logic                 busy;
  logic                 done;
  logic [4*NIBBLES-1:0] s;
  logic                 cout;
  logic                 ovf;

`ifdef NIBBLE_SUB_EN
  modport master (output start, a, b, sub, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, sub, output busy, done, s, cout, ovf);
`else
  modport master (output start, a, b, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, output busy, done, s, cout, ovf);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle adder that reuses one 4-bit carry-lookahead slice for every
//   nibble of the operands, chaining nibbles through a carry register.
//   One nibble of s is written per cycle (LSB first); sum, carry-out and
//   signed overflow are held after done until the next accepted start.
//   Optional macro NIBBLE_SUB_EN: sub=1 captures ~b with carry-in 1 (a-b).
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous active-low reset
//   bus        slave side of nibble_serial_adder_if (start/a/b/[sub] in,
//              busy/done/s/cout/ovf out, all outputs registered)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  nibble_serial_adder_if.slave  bus,
  output logic [1:0]            dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [W-1:0]    opa, opb;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [W-1:0]    s_q;
  logic            cout_q, ovf_q, busy_q, done_q;

  // Subtract select seen at capture; constant 0 when subtraction is built out.
  logic sub_in;
`ifdef NIBBLE_SUB_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Capture happens on any start taken in IDLE or DONE.
  logic accept;
  assign accept = bus.start && (state == IDLE || state == DONE);

  // ---------------- 4-bit carry-lookahead slice ----------------
  logic [3:0] na, nb, g, p, sum;
  logic       c1, c2, c3, c4;
  logic       last;

  assign na = opa[4*idx +: 4];
  assign nb = opb[4*idx +: 4];
  assign g  = na & nb;
  assign p  = na ^ nb;
  assign c1 = g[0] | (p[0] & carry);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & carry);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
  assign sum  = p ^ {c3, c2, c1, carry};
  assign last = (idx == IW'(NIBBLES - 1));

  // ---------------- control FSM and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          s_q[4*idx +: 4] <= sum;
          carry           <= c4;
          idx             <= idx + 1'b1;
          if (last) begin
            cout_q <= c4;
            // Carry into the MSB differs from carry out of it on signed overflow.
            ovf_q  <= c3 ^ c4;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase

      // Operand capture overrides the RUN-side writes only in IDLE/DONE,
      // where RUN writes never happen, so no conflict arises.
      if (accept) begin
        opa    <= bus.a;
        opb    <= sub_in ? ~bus.b : bus.b;
        carry  <= sub_in;
        idx    <= '0;
        s_q    <= '0;
        cout_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Self-checking bench for nibble_serial_adder: directed cases, handshake
//   corner cases and randomized operations; results go through an expected
//   queue popped by an independent monitor on every done pulse.
module tb_nibble_serial_adder;
  logic       clk;
  logic       nrst;
  logic [1:0] dbg_state;

  nibble_serial_adder_if #(.NIBBLES(4)) ifc ();

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (ifc),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {ovf, cout, s}
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic, subtraction as a + ~b + 1.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic sb);
    logic [15:0] bb;
    logic [16:0] t;
    logic        v;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {16'd0, sb};
    v  = (a[15] == bb[15]) && (t[15] != a[15]);
    return {v, t[16], t[15:0]};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  logic [17:0] mon_e;
  always @(negedge clk) begin
    if (nrst && ifc.done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {14'd0, ifc.ovf, ifc.cout, ifc.s}, {14'd0, mon_e});
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one start pulse; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sb);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
`ifdef NIBBLE_SUB_EN
    ifc.sub   = sb;
    exp_q.push_back(model(a, b, sb));
`else
    exp_q.push_back(model(a, b, 1'b0));
`endif
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.a     = 16'($urandom);
    ifc.b     = 16'($urandom);
`ifdef NIBBLE_SUB_EN
    ifc.sub   = 1'($urandom);
`endif
  endtask

  // Issue plus cycle-exact check of busy/done around the operation.
  task automatic run_timed(input logic [15:0] a, input logic [15:0] b, input logic sb);
    issue(a, b, sb);
    for (int i = 0; i < 4; i++) begin
      check("busy_run", {30'd0, ifc.busy, ifc.done}, 32'd2);
      @(posedge clk);
      #1;
    end
    check("done_pulse", {30'd0, ifc.busy, ifc.done}, 32'd1);
    @(posedge clk);
    #1;
    check("after_done", {30'd0, ifc.busy, ifc.done}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {13'd0, ifc.s, ifc.cout, ifc.ovf, ifc.busy, ifc.done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
`ifdef NIBBLE_SUB_EN
    ifc.sub   = 1'b0;
`endif
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    nrst = 1'b1;

    // Directed additions.
    run_timed(16'h1234, 16'h4321, 1'b0);
    run_timed(16'h7FFF, 16'h0001, 1'b0);

    // Full carry ripple: every nibble reads zero while the carry walks up.
    issue(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("ripple_nibbles", {16'd0, ifc.s}, 32'd0);
    end
    repeat (2) @(posedge clk);

`ifdef NIBBLE_SUB_EN
    run_timed(16'h0005, 16'h0007, 1'b1);
    run_timed(16'h8000, 16'h0001, 1'b1);
`endif

    // Reset in the middle of RUN discards the operation.
    issue(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_run");
    nrst = 1'b1;
    run_timed(16'h0F0F, 16'h00F1, 1'b0);

    // start re-asserted during RUN with other operands is ignored.
    issue(16'h2222, 16'h3333, 1'b0);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = 16'hDEAD;
    ifc.b     = 16'hBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);

    // start held high: DONE doubles as the accept cycle, 5 cycles per result.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.a     = 16'($urandom);
      ifc.b     = 16'($urandom);
      exp_q.push_back(model(ifc.a, ifc.b, 1'b0));
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      check("b2b_done", {31'd0, ifc.done}, 32'd1);
    end
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);

    // Randomized operations with random idle gaps.
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 16'hFFFF;
        1: rb = 16'h8000;
        default: ;
      endcase
      rs = 1'($urandom);
      issue(ra, rb, rs);
      repeat (4 + $urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
